hp_mul_rr_arbiter: RTL

- Shares one half-precision multiplier between NUM_REQ independent requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and grants one issue per cycle, round-robin.
- Registers the operands onto the shared unit and tracks in-flight tags through a MUL_LATENCY-deep pipeline.
- Returns the product and the 2-bit exception code to the owning requester through a one-entry response register with valid/ready.
- Sits between compute clients and the combinational/pipelined hp multiplier datapath.

---
 rtl/hp_mul_rr_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hp_mul_rr_arbiter.sv
// Round-robin front end sharing one half-precision multiplier between NUM_REQ
// requesters; tracks in-flight owners and holds one response per requester.
module hp_mul_rr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [16*NUM_REQ-1:0]  rsp_product,
  output logic [2*NUM_REQ-1:0]   rsp_exc,
  output logic [15:0]            mul_in_a,
  output logic [15:0]            mul_in_b,
  output logic                   mul_in_valid,
  input  logic [15:0]            mul_product,
  input  logic [1:0]             mul_exc,
  output logic                   busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned POS_W = IDX_W + 1;

  logic [15:0]            a_arr [NUM_REQ];
  logic [15:0]            b_arr [NUM_REQ];
  logic [NUM_REQ-1:0]     outstanding_q, outstanding_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]     eligible, hs;
  logic [15:0]            prod_q [NUM_REQ];
  logic [15:0]            prod_d [NUM_REQ];
  logic [1:0]             exc_q [NUM_REQ];
  logic [1:0]             exc_d [NUM_REQ];
  logic [IDX_W-1:0]       ptr_q, ptr_d, gidx;
  logic [POS_W-1:0]       pos;
  logic                   found;
  logic [15:0]            mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                   mul_v_q, mul_v_d;
  logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]       tag_idx_q [MUL_LATENCY];
  logic [IDX_W-1:0]       tag_idx_d [MUL_LATENCY];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign a_arr[i]              = req_a[16*i +: 16];
    assign b_arr[i]              = req_b[16*i +: 16];
    assign rsp_product[16*i +: 16] = prod_q[i];
    assign rsp_exc[2*i +: 2]       = exc_q[i];
  end

  // Round-robin scan starting at ptr_q; an outstanding requester is skipped.
  always_comb begin
    eligible  = req_valid & ~outstanding_q;
    found     = 1'b0;
    gidx      = '0;
    pos       = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_q} + POS_W'(k);
      if (pos >= POS_W'(NUM_REQ)) pos = pos - POS_W'(NUM_REQ);
      if (!found && eligible[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        gidx  = pos[IDX_W-1:0];
      end
    end
    if (found) req_ready[gidx] = 1'b1;
  end

  // Next state: response handshakes, tag-pipeline completion, new issue.
  always_comb begin
    hs            = rsp_valid_q & rsp_ready;
    outstanding_d = outstanding_q & ~hs;
    rsp_valid_d   = rsp_valid_q & ~hs;
    prod_d        = prod_q;
    exc_d         = exc_q;
    ptr_d         = ptr_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    mul_v_d       = found;
    tag_vld_d[0]  = found;
    tag_idx_d[0]  = gidx;
    for (int unsigned s = 1; s < MUL_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
    if (tag_vld_q[MUL_LATENCY-1]) begin
      rsp_valid_d[tag_idx_q[MUL_LATENCY-1]] = 1'b1;
      prod_d[tag_idx_q[MUL_LATENCY-1]]      = mul_product;
      exc_d[tag_idx_q[MUL_LATENCY-1]]       = mul_exc;
    end
    if (found) begin
      outstanding_d[gidx] = 1'b1;
      mul_a_d             = a_arr[gidx];
      mul_b_d             = b_arr[gidx];
      ptr_d               = (gidx == IDX_W'(NUM_REQ-1)) ? '0 : gidx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      rsp_valid_q   <= '0;
      ptr_q         <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_v_q       <= 1'b0;
      tag_vld_q     <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        prod_q[i] <= '0;
        exc_q[i]  <= '0;
      end
      for (int unsigned s = 0; s < MUL_LATENCY; s++) tag_idx_q[s] <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      ptr_q         <= ptr_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_v_q       <= mul_v_d;
      tag_vld_q     <= tag_vld_d;
      prod_q        <= prod_d;
      exc_q         <= exc_d;
      tag_idx_q     <= tag_idx_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign mul_in_a     = mul_a_q;
  assign mul_in_b     = mul_b_q;
  assign mul_in_valid = mul_v_q;
  assign busy         = |outstanding_q;

endmodule
